uart_rx: RTL and testbench

//   8N1 UART receiver feeding the command handler: deserialises the board RX pin into

---
 rtl/uart_rx.sv | 139 +++++++++++++
 tb/tb_uart_rx.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, deserialises LSB-first bytes, strobes valid or frame_err.
// Optional even-parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK
  } state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs, rxs_d;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [2:0]             bit_idx, bit_idx_nxt;
  logic [7:0]             shift, shift_nxt;
  logic [7:0]             data_nxt;
  logic                   valid_nxt, frame_nxt, busy_nxt;
  logic                   tick, stop_good;

  assign rxs = sync_q[SYNC_STAGES-1];

  // Metastability chain plus one delayed copy for falling-edge detection
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '1;
      rxs_d  <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      rxs_d  <= rxs;
    end
  end

  // Mid-bit sample point: half a bit into the start bit, a full bit elsewhere
  assign tick = (state == S_START) ? (cnt == HALF_LAST) : (cnt == FULL_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (rxs_d && !rxs) state_nxt = S_START;
      S_START: if (tick) state_nxt = rxs ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
      S_DATA:   if (tick && (bit_idx == 3'd7)) state_nxt = S_PARITY;
      S_PARITY: if (tick) state_nxt = S_STOP;
`else
      S_DATA:  if (tick && (bit_idx == 3'd7)) state_nxt = S_STOP;
`endif
      S_STOP:  if (tick) state_nxt = rxs ? S_IDLE : S_BRK;
      S_BRK:   if (rxs) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  logic par_q, par_nxt, par_bad, perr_nxt;
`endif

  always_comb begin
    cnt_nxt     = cnt + CW'(1);
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    if ((state == S_IDLE) || (state == S_BRK) || tick || (state_nxt != state))
      cnt_nxt = '0;
    if (state != S_DATA)
      bit_idx_nxt = '0;
    else if (tick) begin
      bit_idx_nxt = bit_idx + 3'd1;
      shift_nxt   = {rxs, shift[7:1]};
    end
    stop_good = (state == S_STOP) && tick && rxs;
    frame_nxt = (state == S_STOP) && tick && !rxs;
`ifdef UART_RX_PARITY_EN
    par_nxt   = ((state == S_PARITY) && tick) ? rxs : par_q;
    par_bad   = ^{shift, par_q};
    valid_nxt = stop_good && !par_bad;
    perr_nxt  = stop_good && par_bad;
`else
    valid_nxt = stop_good;
`endif
    data_nxt  = valid_nxt ? shift : data;
    busy_nxt  = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= 8'h00;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift     <= shift_nxt;
      data      <= data_nxt;
      valid     <= valid_nxt;
      frame_err <= frame_nxt;
      busy      <= busy_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_q      <= par_nxt;
      parity_err <= perr_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames pushed as expectations, strobes popped and compared.
// Parity scenario runs only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int unsigned CPB = 8;

  typedef struct packed {
    logic [2:0] kind;  // {valid, frame_err, parity_err}
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data;
  logic       valid, frame_err, busy, perr;

  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         n_cmp = 0;
  int         n_err = 0;

`ifdef UART_RX_PARITY_EN
  logic tx_par_flip = 1'b0;
`endif

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .data(data),
    .valid(valid),
    .frame_err(frame_err),
    .busy(busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(perr)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  // Strobe monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (valid || frame_err || perr) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: got valid=%0b frame_err=%0b parity_err=%0b data=%02h, none expected",
                 valid, frame_err, perr, data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if ({valid, frame_err, perr} !== e.kind || data !== e.data) begin
          n_err++;
          $display("FAIL strobe: got kind=%03b data=%02h, expected kind=%03b data=%02h",
                   {valid, frame_err, perr}, data, e.kind, e.data);
        end
      end
    end
  end

  task automatic rx_bit(input logic b);
    @(negedge clk) rx = b;
    repeat (CPB - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    exp_t e;
    e.data = last_good;
    if (!stop) e.kind = 3'b010;
`ifdef UART_RX_PARITY_EN
    else if (tx_par_flip) e.kind = 3'b001;
`endif
    else begin
      e.kind = 3'b100;
      e.data = d;
      last_good = d;
    end
    exp_q.push_back(e);
    rx_bit(1'b0);
    for (int i = 0; i < 8; i++) rx_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    rx_bit((^d) ^ tx_par_flip);
`endif
    rx_bit(stop);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (data !== 8'h00) begin n_err++; $display("FAIL reset_data: got %02h expected 00", data); end
    n_cmp++; if (valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic test_single;
    send_frame(8'hA5, 1'b1);
    rx_bit(1'b1);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL single_drain: %0d strobes outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    n_cmp++; if (data !== 8'hA5) begin n_err++; $display("FAIL single_data: got %02h expected A5", data); end
  endtask

  task automatic test_back_to_back;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    rx_bit(1'b1);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_drain: %0d strobes outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    n_cmp++; if (data !== 8'hFF) begin n_err++; $display("FAIL b2b_data: got %02h expected FF", data); end
  endtask

  task automatic test_glitch;
    @(negedge clk) rx = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk) rx = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL glitch_busy_high: got %b expected 1", busy); end
    repeat (2 * CPB) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL glitch_busy_low: got %b expected 0", busy); end
    n_cmp++; if (data !== 8'hFF) begin n_err++; $display("FAIL glitch_data: got %02h expected FF", data); end
  endtask

  task automatic test_frame_error;
    send_frame(8'h3C, 1'b0);
    repeat (40 * CPB) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ferr_drain: %0d strobes outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL ferr_break_busy: got %b expected 1", busy); end
    n_cmp++; if (data !== 8'hFF) begin n_err++; $display("FAIL ferr_data_kept: got %02h expected FF", data); end
    rx_bit(1'b1);
    rx_bit(1'b1);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL ferr_idle: busy got %b expected 0", busy); end
    send_frame(8'h55, 1'b1);
    rx_bit(1'b1);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ferr_recover_drain: %0d outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    n_cmp++; if (data !== 8'h55) begin n_err++; $display("FAIL ferr_recover_data: got %02h expected 55", data); end
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] d;
    d = 8'hF0;
    rx_bit(1'b0);
    for (int i = 0; i < 4; i++) rx_bit(d[i]);
    @(negedge clk) rx = d[4];
    repeat (CPB / 2) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL midrst_busy_before: got %b expected 1", busy); end
    reset = 1'b0;
    #1;
    n_cmp++; if (data !== 8'h00) begin n_err++; $display("FAIL midrst_data: got %02h expected 00", data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_cmp++; if (valid !== 1'b0 || frame_err !== 1'b0) begin n_err++; $display("FAIL midrst_strobes: got valid=%b frame_err=%b expected 0 0", valid, frame_err); end
    last_good = 8'h00;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_idle_after: busy got %b expected 0", busy); end
    send_frame(8'h81, 1'b1);
    rx_bit(1'b1);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL midrst_drain: %0d outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    n_cmp++; if (data !== 8'h81) begin n_err++; $display("FAIL midrst_data_after: got %02h expected 81", data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    tx_par_flip = 1'b1;
    send_frame(8'h07, 1'b1);
    rx_bit(1'b1);
    tx_par_flip = 1'b0;
    send_frame(8'h07, 1'b1);
    rx_bit(1'b1);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL parity_drain: %0d outstanding, expected 0", exp_q.size()); exp_q.delete(); end
    n_cmp++; if (data !== 8'h07) begin n_err++; $display("FAIL parity_data: got %02h expected 07", data); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
